// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: round-robin arbiter that lets four LC-3 cores share one
// asynchronous SRAM. One core is granted at a time. The arbiter drives the SRAM
// strobes for ACCESS_CYCLES cycles, then gives the granted core read data and a
// one-cycle memReady.
module shared_mem_arbiter #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [3:0]            mem_oe_n_i,
  input  logic [3:0]            mem_we_n_i,
  input  logic [4*ADDR_W-1:0]   addr_i,
  input  logic [4*DATA_W-1:0]   wdata_i,
  output logic [3:0]            mem_ready_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic [3:0]            grant_o,
  output logic [ADDR_W-1:0]     sram_addr_o,
  output logic [DATA_W-1:0]     sram_dout_o,
  input  logic [DATA_W-1:0]     sram_din_i,
  output logic                  sram_dq_oe_o,
  output logic                  sram_ce_n_o,
  output logic                  sram_oe_n_o,
  output logic                  sram_we_n_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Counter value in the final access cycle. The counter is 4 bits wide,
  // which covers ACCESS_CYCLES up to 15.
  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t              r_state;
  logic [1:0]          r_ptr;
  logic [1:0]          r_gsel;
  logic                r_is_write;
  logic [3:0]          r_cnt;
  logic [DATA_W-1:0]   r_rdata;

  logic [3:0]          w_req;
  logic [3:0]          w_rot;
  logic [1:0]          w_off;
  logic [1:0]          w_pick;

  // A core requests when either of its active-low strobes is low.
  assign w_req = ~mem_oe_n_i | ~mem_we_n_i;

  // Rotate requests so that bit 0 is the core at the round-robin pointer.
  // The lowest set bit is then the first requester at or after ptr.
  always_comb begin
    w_rot  = 4'({w_req, w_req} >> r_ptr);
    casez (w_rot)
      4'b???1: w_off = 2'd0;
      4'b??10: w_off = 2'd1;
      4'b?100: w_off = 2'd2;
      4'b1000: w_off = 2'd3;
      default: w_off = 2'd0;
    endcase
    w_pick = r_ptr + w_off;
  end

  // Arbitration and access sequencing FSM. The access type is fixed at grant.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= 2'd0;
      r_gsel     <= 2'd0;
      r_is_write <= 1'b0;
      r_cnt      <= 4'd0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_req) begin
            r_gsel     <= w_pick;
            r_is_write <= ~mem_we_n_i[w_pick];
            r_cnt      <= 4'd0;
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + 4'd1;
          if (!w_req[r_gsel]) begin
            // Requester gave up. Drop the access and keep the pointer so the
            // same core is still first in line.
            r_state <= S_IDLE;
          end else if (r_cnt == LAST_CNT) begin
            if (!r_is_write) begin
              r_rdata <= sram_din_i;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_ptr   <= r_gsel + 2'd1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output decode from registered state. Address and write data follow the
  // granted core's live inputs, so a MAR that settles late is still seen.
  always_comb begin
    mem_ready_o  = 4'b0000;
    grant_o      = 4'b0000;
    sram_addr_o  = '0;
    sram_dout_o  = '0;
    sram_dq_oe_o = 1'b0;
    sram_ce_n_o  = 1'b1;
    sram_oe_n_o  = 1'b1;
    sram_we_n_o  = 1'b1;
    case (r_state)
      S_ACCESS: begin
        grant_o     = 4'b0001 << r_gsel;
        sram_addr_o = addr_i[r_gsel*ADDR_W +: ADDR_W];
        sram_dout_o = wdata_i[r_gsel*DATA_W +: DATA_W];
        sram_ce_n_o = 1'b0;
        if (r_is_write) begin
          sram_dq_oe_o = 1'b1;
          // WE rises in the last cycle while address and data stay put,
          // which gives the SRAM its data hold time.
          sram_we_n_o  = (r_cnt == LAST_CNT);
        end else begin
          sram_oe_n_o  = 1'b0;
        end
      end
      S_DONE: begin
        grant_o     = 4'b0001 << r_gsel;
        mem_ready_o = 4'b0001 << r_gsel;
        sram_addr_o = addr_i[r_gsel*ADDR_W +: ADDR_W];
        sram_dout_o = wdata_i[r_gsel*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  assign rdata_o = r_rdata;
  assign state_o = r_state;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Testbench for shared_mem_arbiter. Each table row gives the inputs for one
// cycle and the outputs expected in that same cycle. Hand-written code covers
// round-robin rotation.
module tb_shared_mem_arbiter;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [3:0]   mem_oe_n_i;
  logic [3:0]   mem_we_n_i;
  logic [79:0]  addr_i;
  logic [63:0]  wdata_i;
  logic [3:0]   mem_ready_o;
  logic [15:0]  rdata_o;
  logic [3:0]   grant_o;
  logic [19:0]  sram_addr_o;
  logic [15:0]  sram_dout_o;
  logic [15:0]  sram_din_i;
  logic         sram_dq_oe_o;
  logic         sram_ce_n_o;
  logic         sram_oe_n_o;
  logic         sram_we_n_o;
  logic [1:0]   state_o;

  int total = 0;
  int bad   = 0;

  shared_mem_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .mem_oe_n_i(mem_oe_n_i), .mem_we_n_i(mem_we_n_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_ready_o(mem_ready_o), .rdata_o(rdata_o), .grant_o(grant_o),
    .sram_addr_o(sram_addr_o), .sram_dout_o(sram_dout_o), .sram_din_i(sram_din_i),
    .sram_dq_oe_o(sram_dq_oe_o), .sram_ce_n_o(sram_ce_n_o),
    .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o), .state_o(state_o)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic [3:0]  oe_n;
    logic [3:0]  we_n;
    logic [15:0] din;
    logic [1:0]  st;
    logic [3:0]  gnt;
    logic [3:0]  rdy;
    logic [3:0]  strb;   // {ce_n, oe_n, we_n, dq_oe}
    logic [15:0] rd;
    logic [19:0] sa;
    logic [15:0] dout;
  } vec_t;

  localparam int NV = 28;
  vec_t vt[NV];

  function automatic vec_t mk(input logic r, input logic [3:0] oe, input logic [3:0] we,
                              input logic [15:0] di, input logic [1:0] s, input logic [3:0] g,
                              input logic [3:0] ry, input logic [3:0] sb, input logic [15:0] rdv,
                              input logic [19:0] a, input logic [15:0] d);
    vec_t v;
    v.rst = r; v.oe_n = oe; v.we_n = we; v.din = di;
    v.st = s; v.gnt = g; v.rdy = ry; v.strb = sb; v.rd = rdv; v.sa = a; v.dout = d;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  int order[5];
  int tim[5];
  int nready;
  int cyc;
  logic [3:0] req;

  initial begin
    addr_i     = {20'h33333, 20'h00123, 20'h11111, 20'h00010};
    wdata_i    = {16'hA3A3, 16'hA2A2, 16'hA1A1, 16'h1234};
    mem_oe_n_i = 4'hF;
    mem_we_n_i = 4'hF;
    sram_din_i = 16'h0000;
    Reset      = 1'b1;

    //          rst oe    we    din      st    gnt   rdy   strb  rd        addr       dout
    // reset state
    vt[0]  = mk(0, 4'hF, 4'hF, 16'h0000, 2'd0, 4'h0, 4'h0, 4'hE, 16'h0000, 20'h00000, 16'h0000);
    // single read, CPU2
    vt[1]  = mk(0, 4'hB, 4'hF, 16'hBEEF, 2'd0, 4'h0, 4'h0, 4'hE, 16'h0000, 20'h00000, 16'h0000);
    vt[2]  = mk(0, 4'hB, 4'hF, 16'hBEEF, 2'd1, 4'h4, 4'h0, 4'h2, 16'h0000, 20'h00123, 16'hA2A2);
    vt[3]  = mk(0, 4'hB, 4'hF, 16'hBEEF, 2'd1, 4'h4, 4'h0, 4'h2, 16'h0000, 20'h00123, 16'hA2A2);
    vt[4]  = mk(0, 4'hF, 4'hF, 16'hBEEF, 2'd2, 4'h4, 4'h4, 4'hE, 16'hBEEF, 20'h00123, 16'hA2A2);
    vt[5]  = mk(0, 4'hF, 4'hF, 16'hBEEF, 2'd0, 4'h0, 4'h0, 4'hE, 16'hBEEF, 20'h00000, 16'h0000);
    // single write, CPU0 (SRAM bus shows other data; read data must not change)
    vt[6]  = mk(0, 4'hF, 4'hE, 16'hDEAD, 2'd0, 4'h0, 4'h0, 4'hE, 16'hBEEF, 20'h00000, 16'h0000);
    vt[7]  = mk(0, 4'hF, 4'hE, 16'hDEAD, 2'd1, 4'h1, 4'h0, 4'h5, 16'hBEEF, 20'h00010, 16'h1234);
    vt[8]  = mk(0, 4'hF, 4'hE, 16'hDEAD, 2'd1, 4'h1, 4'h0, 4'h7, 16'hBEEF, 20'h00010, 16'h1234);
    vt[9]  = mk(0, 4'hF, 4'hF, 16'hDEAD, 2'd2, 4'h1, 4'h1, 4'hE, 16'hBEEF, 20'h00010, 16'h1234);
    vt[10] = mk(0, 4'hF, 4'hF, 16'hDEAD, 2'd0, 4'h0, 4'h0, 4'hE, 16'hBEEF, 20'h00000, 16'h0000);
    // abort, CPU1 drops OE in first access cycle
    vt[11] = mk(0, 4'hD, 4'hF, 16'hDEAD, 2'd0, 4'h0, 4'h0, 4'hE, 16'hBEEF, 20'h00000, 16'h0000);
    vt[12] = mk(0, 4'hF, 4'hF, 16'hDEAD, 2'd1, 4'h2, 4'h0, 4'h2, 16'hBEEF, 20'h11111, 16'hA1A1);
    vt[13] = mk(0, 4'hF, 4'hF, 16'h5A5A, 2'd0, 4'h0, 4'h0, 4'hE, 16'hBEEF, 20'h00000, 16'h0000);
    // CPU1 and CPU2 request; pointer is still 1 so CPU1 wins
    vt[14] = mk(0, 4'h9, 4'hF, 16'h5A5A, 2'd0, 4'h0, 4'h0, 4'hE, 16'hBEEF, 20'h00000, 16'h0000);
    vt[15] = mk(0, 4'h9, 4'hF, 16'h5A5A, 2'd1, 4'h2, 4'h0, 4'h2, 16'hBEEF, 20'h11111, 16'hA1A1);
    vt[16] = mk(0, 4'h9, 4'hF, 16'h5A5A, 2'd1, 4'h2, 4'h0, 4'h2, 16'hBEEF, 20'h11111, 16'hA1A1);
    vt[17] = mk(0, 4'hF, 4'hF, 16'h5A5A, 2'd2, 4'h2, 4'h2, 4'hE, 16'h5A5A, 20'h11111, 16'hA1A1);
    vt[18] = mk(0, 4'hF, 4'hF, 16'h5A5A, 2'd0, 4'h0, 4'h0, 4'hE, 16'h5A5A, 20'h00000, 16'h0000);
    // reset during cnt=0 of a CPU3 write
    vt[19] = mk(0, 4'hF, 4'h7, 16'h5A5A, 2'd0, 4'h0, 4'h0, 4'hE, 16'h5A5A, 20'h00000, 16'h0000);
    vt[20] = mk(1, 4'hF, 4'h7, 16'h5A5A, 2'd1, 4'h8, 4'h0, 4'h5, 16'h5A5A, 20'h33333, 16'hA3A3);
    vt[21] = mk(0, 4'hF, 4'hF, 16'h5A5A, 2'd0, 4'h0, 4'h0, 4'hE, 16'h0000, 20'h00000, 16'h0000);
    vt[22] = mk(0, 4'hF, 4'hF, 16'h5A5A, 2'd0, 4'h0, 4'h0, 4'hE, 16'h0000, 20'h00000, 16'h0000);
    // CPU1 OE and WE both low -> write; switching to OE-only mid-access stays a write
    vt[23] = mk(0, 4'hD, 4'hD, 16'h7777, 2'd0, 4'h0, 4'h0, 4'hE, 16'h0000, 20'h00000, 16'h0000);
    vt[24] = mk(0, 4'hD, 4'hD, 16'h7777, 2'd1, 4'h2, 4'h0, 4'h5, 16'h0000, 20'h11111, 16'hA1A1);
    vt[25] = mk(0, 4'hD, 4'hF, 16'h7777, 2'd1, 4'h2, 4'h0, 4'h7, 16'h0000, 20'h11111, 16'hA1A1);
    vt[26] = mk(0, 4'hF, 4'hF, 16'h7777, 2'd2, 4'h2, 4'h2, 4'hE, 16'h0000, 20'h11111, 16'hA1A1);
    vt[27] = mk(0, 4'hF, 4'hF, 16'h7777, 2'd0, 4'h0, 4'h0, 4'hE, 16'h0000, 20'h00000, 16'h0000);

    @(posedge Clk);
    @(posedge Clk);
    #1;
    for (int i = 0; i < NV; i++) begin
      @(posedge Clk);
      #1;
      Reset      = vt[i].rst;
      mem_oe_n_i = vt[i].oe_n;
      mem_we_n_i = vt[i].we_n;
      sram_din_i = vt[i].din;
      @(negedge Clk);
      chk("state", i, 32'(state_o), 32'(vt[i].st));
      chk("grant", i, 32'(grant_o), 32'(vt[i].gnt));
      chk("ready", i, 32'(mem_ready_o), 32'(vt[i].rdy));
      chk("strobes", i, 32'({sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_dq_oe_o}), 32'(vt[i].strb));
      chk("rdata", i, 32'(rdata_o), 32'(vt[i].rd));
      chk("sram_addr", i, 32'(sram_addr_o), 32'(vt[i].sa));
      chk("sram_dout", i, 32'(sram_dout_o), 32'(vt[i].dout));
    end

    // Round robin: all four read from reset; CPU0 re-requests after its turn.
    @(posedge Clk);
    #1;
    Reset      = 1'b1;
    mem_oe_n_i = 4'hF;
    mem_we_n_i = 4'hF;
    sram_din_i = 16'h0000;
    @(posedge Clk);
    #1;
    Reset  = 1'b0;
    req    = 4'b1111;
    nready = 0;
    cyc    = 0;
    for (int i = 0; i < 5; i++) begin
      order[i] = -1;
      tim[i]   = -1;
    end
    while (cyc < 40 && nready < 5) begin
      @(posedge Clk);
      #1;
      mem_oe_n_i = ~req;
      @(negedge Clk);
      cyc++;
      if (mem_ready_o != 4'b0000) begin
        chk("rr_onehot", nready, 32'($onehot(mem_ready_o)), 32'd1);
        for (int k = 0; k < 4; k++) begin
          if (mem_ready_o[k]) order[nready] = k;
        end
        tim[nready] = cyc;
        nready++;
        req = req & ~mem_ready_o;
      end
      if (cyc == 6) req[0] = 1'b1;
    end
    chk("rr_count", 0, 32'(nready), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("rr_order", i, 32'(order[i]), 32'(i % 4));
      chk("rr_time", i, 32'(tim[i]), 32'(4 + 4 * i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Round-robin arbiter sharing one asynchronous SRAM among the four LC-3 cores (CPU0 = master, CPU1–3 = slaves). Each core's ISDU requests memory by driving its active-low Mem_OE/Mem_WE and waits in its memory states until its memReady is asserted. This block grants one core at a time, sequences the SRAM strobes, and returns read data plus a one-cycle memReady to the granted core.

## Interface
- ADDR_W, 20, SRAM address width
- DATA_W, 16, data width
- ACCESS_CYCLES, 2, SRAM access length in cycles; legal range 2–15
- Clk  in  1  system clock
- Reset  in  1  Reset, synchronous, active-high; clock Clk
- mem_oe_n_i  in  4  per-core Mem_OE (active low); bit k = CPUk
- mem_we_n_i  in  4  per-core Mem_WE (active low)
- addr_i  in  4*ADDR_W  per-core MAR; CPUk at [k*ADDR_W +: ADDR_W]
- wdata_i  in  4*DATA_W  per-core MDR; CPUk at [k*DATA_W +: DATA_W]
- mem_ready_o  out  4  per-core memReady, one-hot or zero
- rdata_o  out  DATA_W  read data, broadcast to all cores
- grant_o  out  4  one-hot granted core, zero when idle
- sram_addr_o  out  ADDR_W  SRAM address
- sram_dout_o  out  DATA_W  SRAM write data
- sram_din_i  in  DATA_W  SRAM read data
- sram_dq_oe_o  out  1  tristate enable for sram_dout_o
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  SRAM strobes, active low
- state_o  out  2  FSM state (IDLE=0, ACCESS=1, DONE=2)

## Operation
- Core k requests when mem_oe_n_i[k]==0 or mem_we_n_i[k]==0. If both are low, the request is a write.
- FSM states:
  - IDLE: with any request pending, pick the first requester at or after round-robin pointer `ptr`, searching upward and wrapping 3→0. Register `gsel` and `is_write`, clear counter `cnt`, go to ACCESS. With no request, stay in IDLE.
  - ACCESS: `cnt` increments each cycle.
    - If the granted core drops its request (both strobes high), abort: go to IDLE with no memReady and no `ptr` change.
    - When `cnt==ACCESS_CYCLES-1`, a read latches sram_din_i into `rdata_q`. Go to DONE.
  - DONE: mem_ready_o[gsel]=1, `ptr`←gsel+1 (mod 4), go to IDLE.
- The address and write data are not latched. While granted, sram_addr_o and sram_dout_o follow the granted core's live addr_i/wdata_i. This lets a core that raises OE in its fetch state before MAR settles still read the settled MAR.
- Type is fixed at grant. A core that changes OE↔WE mid-access keeps the original type.
- Outputs in IDLE:
  - grant_o=0, sram_ce_n_o=1, sram_oe_n_o=1, sram_we_n_o=1, sram_dq_oe_o=0.
  - sram_addr_o=0.
  - rdata_o=`rdata_q`, which holds its last value.
- Outputs in ACCESS:
  - sram_ce_n_o=0.
  - Read: sram_oe_n_o=0.
  - Write: sram_dq_oe_o=1, and sram_we_n_o=0 for `cnt` < ACCESS_CYCLES-1. WE rises in the last cycle while address and data are held, giving data hold.
- Outputs in DONE: SRAM strobes inactive, grant_o still one-hot.
- Reset values:
  - State IDLE, `ptr`=0, `gsel`=0, `cnt`=0, `rdata_q`=0.
  - All outputs take their IDLE values, and mem_ready_o=0.
- Reset asserted mid-access forces IDLE at the next edge. No memReady is issued and the SRAM strobes deassert that cycle.

## Timing
- Request first seen in IDLE at cycle t:
  - grant_o valid at t+1.
  - ACCESS spans t+1..t+ACCESS_CYCLES.
  - DONE at t+ACCESS_CYCLES+1, where mem_ready_o and rdata_o are valid in the same cycle.
  - The ISDU's LD_MDR captures the data at the end of that cycle.
- Per-access occupancy is ACCESS_CYCLES+2 cycles including the IDLE re-arbitration cycle. Back-to-back grants to different cores are separated by exactly one IDLE cycle.
- The mem_ready_o pulse is exactly one cycle. The requester must deassert its strobe on the following cycle or it is treated as a new request.
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0,… and no core waits more than 3 full accesses.
- All outputs are registered-state decodes. There is no combinational path from a mem_*_n_i input to mem_ready_o.

## Test plan
- Single read: CPU2 OE low, addr 0x00123, SRAM returns 0xBEEF. Expect grant_o=4'b0100 at t+1, sram_oe_n_o low for 2 cycles, mem_ready_o=4'b0100 with rdata_o=0xBEEF at t+3, one cycle only.
- Single write: CPU0 WE low, addr 0x00010, wdata 0x1234. Expect sram_dq_oe_o=1 for 2 cycles, sram_we_n_o low only in the first cycle, sram_dout_o=0x1234, mem_ready_o=4'b0001 at t+3.
- Round robin: all four request reads from reset. Expect grants 0,1,2,3 with each mem_ready pulse 4 cycles apart. CPU0 then re-requests and is granted after CPU3.
- Abort: CPU1 drops OE in the first ACCESS cycle. Expect IDLE next cycle, no mem_ready_o, and `ptr` unchanged so CPU1 wins again on re-request.
- Reset mid-write: Reset at cnt=0 of a CPU3 write. Expect all SRAM strobes high and state_o=0 next cycle, with no memReady issued.
- OE and WE both low on CPU1: performed as a write.
